// File: rtl/apb_reg_bank_pkg.sv
// Shared types, constants and helpers for the APB register bank.
package apb_reg_pkg;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_e;

  localparam int unsigned APB_STRB_W = 4;
  localparam int unsigned WORD_SHIFT = 2;
  localparam int unsigned MAX_WAIT   = 15;

  // Replace only the byte lanes whose strobe bit is set.
  function automatic logic [31:0] strb_merge(input logic [31:0]           old,
                                             input logic [31:0]           wdata,
                                             input logic [APB_STRB_W-1:0] strb);
    logic [31:0] r;
    r = old;
    for (int unsigned b = 0; b < APB_STRB_W; b++) begin
      if (strb[b]) r[8*b +: 8] = wdata[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/apb_reg_bank_if.sv
// APB4 bus bundle between the interconnect (master) and the register bank (slave).
interface apb_reg_bank_if;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata, pstrb,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata, pstrb,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/apb_reg_bank_addr_decode.sv
// Combinational address decode: byte address -> register index, hit and error flags.
module apb_addr_decode
  import apb_reg_pkg::*;
#(
  parameter logic [31:0]          BASE_ADDR = 32'h0000_0000,
  parameter int unsigned          NUM_REGS  = 4,
  parameter int unsigned          IDX_W     = 2,
  parameter logic [NUM_REGS-1:0]  RO_MASK   = 4'b1000
) (
  input  logic [31:0]      paddr,
  input  logic             pwrite,
  output logic [IDX_W-1:0] idx,
  output logic             hit,
  output logic             err
);

  logic [31:0] off;
  logic [31:0] off_w;

  // Offset from base, word index, and legality of the access.
  always_comb begin
    off   = paddr - BASE_ADDR;
    off_w = off >> WORD_SHIFT;
    idx   = off_w[IDX_W-1:0];
    hit   = (off[1:0] == 2'b00) && (paddr >= BASE_ADDR) && (off_w < 32'(NUM_REGS));
    err   = !hit || (pwrite && RO_MASK[idx]);
  end

endmodule

// File: rtl/apb_reg_bank.sv
// Parametrised APB4 slave register bank with RO/RW registers, byte strobes,
// programmable wait states, pslverr reporting and per-register write strobes.
module apb_reg_bank
  import apb_reg_pkg::*;
#(
  parameter int unsigned         DATA_W      = 32,
  parameter int unsigned         NUM_REGS    = 4,
  parameter logic [31:0]         BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned         WAIT_STATES = 1,
  parameter logic [NUM_REGS-1:0] RO_MASK     = 4'b1000,
  parameter logic [31:0]         RST_VAL     = 32'h0
) (
  input  logic                       pclk,
  input  logic                       preset_n,
  apb_reg_bank_if.slave              bus,
  output logic [NUM_REGS*DATA_W-1:0] reg_out,
  input  logic [NUM_REGS*DATA_W-1:0] reg_in,
  output logic [NUM_REGS-1:0]        reg_wr_stb
);

  localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  if (DATA_W != 32) begin : g_chk_dw
    $error("apb_reg_bank: DATA_W must be 32");
  end
  if (NUM_REGS < 1 || NUM_REGS > 64) begin : g_chk_nr
    $error("apb_reg_bank: NUM_REGS must be 1..64");
  end
  if (WAIT_STATES > MAX_WAIT) begin : g_chk_ws
    $error("apb_reg_bank: WAIT_STATES must be 0..15");
  end
  if (BASE_ADDR[1:0] != 2'b00) begin : g_chk_ba
    $error("apb_reg_bank: BASE_ADDR must be word-aligned");
  end

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             err_q, err_d;
  logic             hit_q, hit_d;
  logic             wr_q, wr_d;

  logic [IDX_W-1:0] dec_idx;
  logic             dec_hit;
  logic             dec_err;

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              pready;
  logic              complete;
  logic              commit;
  logic              rd_ok;

  apb_addr_decode #(
    .BASE_ADDR (BASE_ADDR),
    .NUM_REGS  (NUM_REGS),
    .IDX_W     (IDX_W),
    .RO_MASK   (RO_MASK)
  ) u_decode (
    .paddr  (bus.paddr),
    .pwrite (bus.pwrite),
    .idx    (dec_idx),
    .hit    (dec_hit),
    .err    (dec_err)
  );

  assign pready   = (state_q == ACCESS) && (cnt_q == 4'd0);
  assign complete = pready && bus.psel && bus.penable;
  assign commit   = complete && wr_q && !err_q;
  assign rd_ok    = pready && !wr_q && hit_q && !err_q;

  // FSM state, wait counter and setup-phase transfer attributes.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      hit_q   <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      hit_q   <= hit_d;
      wr_q    <= wr_d;
    end
  end

  // Next-state logic: latch decode at setup, count wait states, finish or abort.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    err_d   = err_q;
    hit_d   = hit_q;
    wr_d    = wr_q;
    case (state_q)
      IDLE: begin
        if (bus.psel && !bus.penable) begin
          state_d = ACCESS;
          cnt_d   = 4'(WAIT_STATES);
          idx_d   = dec_idx;
          err_d   = dec_err;
          hit_d   = dec_hit;
          wr_d    = bus.pwrite;
        end
      end
      ACCESS: begin
        if (!bus.psel) begin
          state_d = IDLE;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (bus.penable) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Register array: byte-lane merge on an error-free write completion.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= RST_VAL;
    end else if (commit) begin
      regs[idx_q] <= strb_merge(regs[idx_q], bus.pwdata, bus.pstrb);
    end
  end

  // One-cycle write strobe, aligned with the updated register contents.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      reg_wr_stb <= '0;
    end else begin
      reg_wr_stb <= '0;
      if (commit) reg_wr_stb[idx_q] <= 1'b1;
    end
  end

  // Flattened RW view, read mux and completion-phase response.
  always_comb begin
    reg_out = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (!RO_MASK[i]) reg_out[i*DATA_W +: DATA_W] = regs[i];
    end
    bus.prdata = '0;
    if (rd_ok) begin
      bus.prdata = RO_MASK[idx_q] ? reg_in[idx_q*DATA_W +: DATA_W] : regs[idx_q];
    end
    bus.pready  = pready;
    bus.pslverr = pready && err_q;
  end

endmodule

// File: tb/tb_apb_reg_bank.sv
// Directed bench for apb_reg_bank: main instance (1 wait state) plus
// 0- and 3-wait-state instances for the wait-state sweep.
module tb_apb_reg_bank;

  logic pclk = 1'b0;
  logic preset_n = 1'b0;
  always #5 pclk = ~pclk;

  logic [31:0]  t_paddr = '0;
  logic [31:0]  t_pwdata = '0;
  logic         t_psel = 1'b0;
  logic         t_penable = 1'b0;
  logic         t_pwrite = 1'b0;
  logic [3:0]   t_pstrb = '0;
  int           target = 0;
  logic [127:0] reg_in_tb = '0;

  apb_reg_bank_if bus_a ();
  apb_reg_bank_if bus_z ();
  apb_reg_bank_if bus_w ();

  assign bus_a.paddr = t_paddr;  assign bus_a.pwdata = t_pwdata; assign bus_a.pstrb = t_pstrb;
  assign bus_a.pwrite = t_pwrite; assign bus_a.penable = t_penable; assign bus_a.psel = t_psel && (target == 0);
  assign bus_z.paddr = t_paddr;  assign bus_z.pwdata = t_pwdata; assign bus_z.pstrb = t_pstrb;
  assign bus_z.pwrite = t_pwrite; assign bus_z.penable = t_penable; assign bus_z.psel = t_psel && (target == 1);
  assign bus_w.paddr = t_paddr;  assign bus_w.pwdata = t_pwdata; assign bus_w.pstrb = t_pstrb;
  assign bus_w.pwrite = t_pwrite; assign bus_w.penable = t_penable; assign bus_w.psel = t_psel && (target == 2);

  logic [127:0] ro_a, ro_z, ro_w;
  logic [3:0]   stb_a, stb_z, stb_w;

  apb_reg_bank #(.DATA_W(32), .NUM_REGS(4), .BASE_ADDR(32'h0), .WAIT_STATES(1),
                 .RO_MASK(4'b1000), .RST_VAL(32'h0)) dut (
    .pclk(pclk), .preset_n(preset_n), .bus(bus_a), .reg_out(ro_a), .reg_in(reg_in_tb), .reg_wr_stb(stb_a));
  apb_reg_bank #(.DATA_W(32), .NUM_REGS(4), .BASE_ADDR(32'h0), .WAIT_STATES(0),
                 .RO_MASK(4'b1000), .RST_VAL(32'h0)) dut_ws0 (
    .pclk(pclk), .preset_n(preset_n), .bus(bus_z), .reg_out(ro_z), .reg_in(reg_in_tb), .reg_wr_stb(stb_z));
  apb_reg_bank #(.DATA_W(32), .NUM_REGS(4), .BASE_ADDR(32'h0), .WAIT_STATES(3),
                 .RO_MASK(4'b1000), .RST_VAL(32'h0)) dut_ws3 (
    .pclk(pclk), .preset_n(preset_n), .bus(bus_w), .reg_out(ro_w), .reg_in(reg_in_tb), .reg_wr_stb(stb_w));

  logic         m_pready, m_pslverr;
  logic [31:0]  m_prdata;
  logic [127:0] m_reg_out;
  logic [3:0]   m_stb;

  always_comb begin
    m_pready = bus_a.pready; m_pslverr = bus_a.pslverr; m_prdata = bus_a.prdata;
    m_reg_out = ro_a; m_stb = stb_a;
    if (target == 1) begin
      m_pready = bus_z.pready; m_pslverr = bus_z.pslverr; m_prdata = bus_z.prdata;
      m_reg_out = ro_z; m_stb = stb_z;
    end else if (target == 2) begin
      m_pready = bus_w.pready; m_pslverr = bus_w.pslverr; m_prdata = bus_w.prdata;
      m_reg_out = ro_w; m_stb = stb_w;
    end
  end

  int checks = 0;
  int passes = 0;

  int          st;
  logic [31:0] rd;
  logic        er;
  logic [3:0]  sb;

  // One APB transfer; entered and left at #1 after a rising edge, so calls chain back-to-back.
  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] data,
                      input logic [3:0] strb, output int stall, output logic [31:0] rdata,
                      output logic err, output logic [3:0] stb);
    t_paddr = addr; t_pwrite = wr; t_pwdata = data; t_pstrb = strb;
    t_psel = 1'b1; t_penable = 1'b0;
    @(posedge pclk); #1;
    t_penable = 1'b1;
    stall = 0;
    while (!m_pready && stall < 20) begin
      @(posedge pclk); #1;
      stall++;
    end
    if (!m_pready) begin
      checks++;
      $display("FAIL xfer_timeout: pready=%b after %0d cycles, required 1", m_pready, stall);
    end
    rdata = m_prdata;
    err   = m_pslverr;
    @(posedge pclk); #1;
    t_psel = 1'b0; t_penable = 1'b0;
    stb = m_stb;
  endtask

  task automatic test_reset();
    preset_n = 1'b0;
    #1;
    checks++; if (m_pready !== 1'b0) $display("FAIL rst_pready: got %b want 0", m_pready); else passes++;
    checks++; if (m_pslverr !== 1'b0) $display("FAIL rst_pslverr: got %b want 0", m_pslverr); else passes++;
    checks++; if (m_prdata !== 32'h0) $display("FAIL rst_prdata: got %h want 0", m_prdata); else passes++;
    checks++; if (m_stb !== 4'h0) $display("FAIL rst_stb: got %b want 0000", m_stb); else passes++;
    checks++; if (m_reg_out !== 128'h0) $display("FAIL rst_reg_out: got %h want 0", m_reg_out); else passes++;
    @(posedge pclk); #1;
    preset_n = 1'b1;
    @(posedge pclk); #1;
  endtask

  task automatic test_write_read();
    xfer(32'h0, 1'b1, 32'hDEAD_BEEF, 4'hF, st, rd, er, sb);
    checks++; if (st !== 1) $display("FAIL wr0_stall: got %0d want 1", st); else passes++;
    checks++; if (er !== 1'b0) $display("FAIL wr0_pslverr: got %b want 0", er); else passes++;
    checks++; if (sb !== 4'b0001) $display("FAIL wr0_stb: got %b want 0001", sb); else passes++;
    checks++; if (m_reg_out[31:0] !== 32'hDEAD_BEEF) $display("FAIL wr0_reg: got %h want deadbeef", m_reg_out[31:0]); else passes++;
    xfer(32'h0, 1'b0, 32'h0, 4'h0, st, rd, er, sb);
    checks++; if (rd !== 32'hDEAD_BEEF) $display("FAIL rd0_prdata: got %h want deadbeef", rd); else passes++;
    checks++; if (er !== 1'b0) $display("FAIL rd0_pslverr: got %b want 0", er); else passes++;
    checks++; if (sb !== 4'b0000) $display("FAIL rd0_stb: got %b want 0000", sb); else passes++;
  endtask

  task automatic test_partial_strobe();
    xfer(32'h4, 1'b1, 32'h1122_3344, 4'hF, st, rd, er, sb);
    xfer(32'h4, 1'b1, 32'hAABB_CCDD, 4'b0101, st, rd, er, sb);
    checks++; if (m_reg_out[63:32] !== 32'h11BB_33DD) $display("FAIL part_reg1: got %h want 11bb33dd", m_reg_out[63:32]); else passes++;
    checks++; if (sb !== 4'b0010) $display("FAIL part_stb: got %b want 0010", sb); else passes++;
    xfer(32'h4, 1'b0, 32'h0, 4'h0, st, rd, er, sb);
    checks++; if (rd !== 32'h11BB_33DD) $display("FAIL part_rd: got %h want 11bb33dd", rd); else passes++;
  endtask

  task automatic test_read_only();
    reg_in_tb[127:96] = 32'hCAFE_0001;
    xfer(32'hC, 1'b1, 32'h5, 4'hF, st, rd, er, sb);
    checks++; if (er !== 1'b1) $display("FAIL ro_wr_pslverr: got %b want 1", er); else passes++;
    checks++; if (sb !== 4'b0000) $display("FAIL ro_wr_stb: got %b want 0000", sb); else passes++;
    checks++; if (m_reg_out[127:96] !== 32'h0) $display("FAIL ro_reg_out: got %h want 0", m_reg_out[127:96]); else passes++;
    xfer(32'hC, 1'b0, 32'h0, 4'h0, st, rd, er, sb);
    checks++; if (rd !== 32'hCAFE_0001) $display("FAIL ro_rd_prdata: got %h want cafe0001", rd); else passes++;
    checks++; if (er !== 1'b0) $display("FAIL ro_rd_pslverr: got %b want 0", er); else passes++;
  endtask

  task automatic test_decode_err();
    xfer(32'h10, 1'b0, 32'h0, 4'h0, st, rd, er, sb);
    checks++; if (er !== 1'b1) $display("FAIL oor_pslverr: got %b want 1", er); else passes++;
    checks++; if (rd !== 32'h0) $display("FAIL oor_prdata: got %h want 0", rd); else passes++;
    xfer(32'h2, 1'b0, 32'h0, 4'h0, st, rd, er, sb);
    checks++; if (er !== 1'b1) $display("FAIL mis_pslverr: got %b want 1", er); else passes++;
    checks++; if (rd !== 32'h0) $display("FAIL mis_prdata: got %h want 0", rd); else passes++;
    xfer(32'h10, 1'b1, 32'hFFFF_FFFF, 4'hF, st, rd, er, sb);
    checks++; if (er !== 1'b1) $display("FAIL oor_wr_pslverr: got %b want 1", er); else passes++;
    checks++; if (sb !== 4'b0000) $display("FAIL oor_wr_stb: got %b want 0000", sb); else passes++;
  endtask

  task automatic test_pstrb_zero();
    xfer(32'h8, 1'b1, 32'hFFFF_FFFF, 4'h0, st, rd, er, sb);
    checks++; if (sb !== 4'b0100) $display("FAIL z_strb_stb: got %b want 0100", sb); else passes++;
    checks++; if (m_reg_out[95:64] !== 32'h0) $display("FAIL z_strb_reg2: got %h want 0", m_reg_out[95:64]); else passes++;
    checks++; if (er !== 1'b0) $display("FAIL z_strb_pslverr: got %b want 0", er); else passes++;
  endtask

  task automatic test_wait_sweep();
    target = 1;
    xfer(32'h0, 1'b1, 32'h0000_A0A0, 4'hF, st, rd, er, sb);
    checks++; if (st !== 0) $display("FAIL ws0_wr_stall: got %0d want 0", st); else passes++;
    checks++; if (sb !== 4'b0001) $display("FAIL ws0_wr_stb: got %b want 0001", sb); else passes++;
    xfer(32'h4, 1'b1, 32'h0000_B1B1, 4'hF, st, rd, er, sb);
    checks++; if (sb !== 4'b0010) $display("FAIL ws0_b2b_stb: got %b want 0010", sb); else passes++;
    xfer(32'h0, 1'b0, 32'h0, 4'h0, st, rd, er, sb);
    checks++; if (st !== 0) $display("FAIL ws0_rd_stall: got %0d want 0", st); else passes++;
    checks++; if (rd !== 32'h0000_A0A0) $display("FAIL ws0_rd_prdata: got %h want 0000a0a0", rd); else passes++;
    checks++; if (m_reg_out[63:0] !== 64'h0000_B1B1_0000_A0A0) $display("FAIL ws0_regs: got %h want 0000b1b10000a0a0", m_reg_out[63:0]); else passes++;
    target = 2;
    xfer(32'h4, 1'b1, 32'h0000_C3C3, 4'hF, st, rd, er, sb);
    checks++; if (st !== 3) $display("FAIL ws3_wr_stall: got %0d want 3", st); else passes++;
    checks++; if (sb !== 4'b0010) $display("FAIL ws3_wr_stb: got %b want 0010", sb); else passes++;
    xfer(32'h4, 1'b0, 32'h0, 4'h0, st, rd, er, sb);
    checks++; if (st !== 3) $display("FAIL ws3_rd_stall: got %0d want 3", st); else passes++;
    checks++; if (rd !== 32'h0000_C3C3) $display("FAIL ws3_rd_prdata: got %h want 0000c3c3", rd); else passes++;
    target = 0;
  endtask

  task automatic test_back_to_back();
    xfer(32'h0, 1'b1, 32'h0102_0304, 4'hF, st, rd, er, sb);
    checks++; if (sb !== 4'b0001) $display("FAIL b2b_stb0: got %b want 0001", sb); else passes++;
    xfer(32'h4, 1'b1, 32'h0506_0708, 4'hF, st, rd, er, sb);
    checks++; if (sb !== 4'b0010) $display("FAIL b2b_stb1: got %b want 0010", sb); else passes++;
    checks++; if (st !== 1) $display("FAIL b2b_stall: got %0d want 1", st); else passes++;
    checks++; if (m_reg_out[63:0] !== 64'h0506_0708_0102_0304) $display("FAIL b2b_regs: got %h want 0506070801020304", m_reg_out[63:0]); else passes++;
    xfer(32'h4, 1'b0, 32'h0, 4'h0, st, rd, er, sb);
    checks++; if (rd !== 32'h0506_0708) $display("FAIL b2b_rd: got %h want 05060708", rd); else passes++;
  endtask

  task automatic test_reset_mid();
    t_paddr = 32'h8; t_pwrite = 1'b1; t_pwdata = 32'h1234; t_pstrb = 4'hF;
    t_psel = 1'b1; t_penable = 1'b0;
    @(posedge pclk); #1;
    t_penable = 1'b1;
    checks++; if (m_pready !== 1'b0) $display("FAIL mid_stall_pready: got %b want 0", m_pready); else passes++;
    preset_n = 1'b0;
    #1;
    checks++; if (m_pready !== 1'b0) $display("FAIL mid_rst_pready: got %b want 0", m_pready); else passes++;
    checks++; if (m_reg_out[31:0] !== 32'h0) $display("FAIL mid_rst_reg0: got %h want 0", m_reg_out[31:0]); else passes++;
    t_psel = 1'b0; t_penable = 1'b0;
    #1;
    preset_n = 1'b1;
    @(posedge pclk); #1;
    checks++; if (m_reg_out[95:64] !== 32'h0) $display("FAIL mid_reg2: got %h want 0", m_reg_out[95:64]); else passes++;
    checks++; if (m_stb !== 4'b0000) $display("FAIL mid_stb: got %b want 0000", m_stb); else passes++;
    xfer(32'h8, 1'b1, 32'h0000_0055, 4'hF, st, rd, er, sb);
    checks++; if (st !== 1) $display("FAIL mid_next_stall: got %0d want 1", st); else passes++;
    checks++; if (sb !== 4'b0100) $display("FAIL mid_next_stb: got %b want 0100", sb); else passes++;
    checks++; if (m_reg_out[95:64] !== 32'h0000_0055) $display("FAIL mid_next_reg2: got %h want 00000055", m_reg_out[95:64]); else passes++;
  endtask

  task automatic test_psel_drop();
    t_paddr = 32'h4; t_pwrite = 1'b1; t_pwdata = 32'hFFFF_FFFF; t_pstrb = 4'hF;
    t_psel = 1'b1; t_penable = 1'b0;
    @(posedge pclk); #1;
    t_psel = 1'b0; t_penable = 1'b0;
    @(posedge pclk); #1;
    checks++; if (m_stb !== 4'b0000) $display("FAIL drop_stb0: got %b want 0000", m_stb); else passes++;
    @(posedge pclk); #1;
    checks++; if (m_stb !== 4'b0000) $display("FAIL drop_stb1: got %b want 0000", m_stb); else passes++;
    checks++; if (m_reg_out[63:32] !== 32'h0) $display("FAIL drop_reg1: got %h want 0", m_reg_out[63:32]); else passes++;
    checks++; if (m_pready !== 1'b0) $display("FAIL drop_pready: got %b want 0", m_pready); else passes++;
    xfer(32'h4, 1'b0, 32'h0, 4'h0, st, rd, er, sb);
    checks++; if (rd !== 32'h0) $display("FAIL drop_rd: got %h want 0", rd); else passes++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_partial_strobe();
    test_read_only();
    test_decode_err();
    test_pstrb_zero();
    test_wait_sweep();
    test_back_to_back();
    test_reset_mid();
    test_psel_drop();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule

// File: doc/apb_reg_bank.md
Name: apb_reg_bank

Overview:
Parametrised APB4 slave register bank. It is the successor to the fixed two-register APB communicator.
- Generalised to NUM_REGS word registers, with per-register read-only/read-write mode, byte strobes and a programmable wait-state count.
- Reports errors via pslverr and emits per-register write strobes.
- Sits between the APB interconnect and the bridge core. RW registers drive core configuration/data; RO registers expose core status.

Parameters:
- DATA_W, 32, data width; must be 32 (pstrb is 4 bits).
- NUM_REGS, 4, number of word registers, 1..64.
- BASE_ADDR, 32'h0000_0000, byte address of register 0; word-aligned.
- WAIT_STATES, 1, number of access-phase cycles with pready=0 before completion, 0..15.
- RO_MASK, 4'b1000, NUM_REGS bits; bit i=1 makes register i read-only.
- RST_VAL, 32'h0, reset value of every RW register.

Ports:
- pclk  in  1  APB clock; the single clock of the block.
- preset_n  in  1  asynchronous active-low reset.
- paddr  in  32  byte address.
- psel  in  1  slave select.
- penable  in  1  access phase.
- pwrite  in  1  1=write, 0=read.
- pwdata  in  32  write data.
- pstrb  in  4  write byte lanes.
- pready  out  1  transfer complete.
- prdata  out  32  read data, valid when pready=1.
- pslverr  out  1  error, valid when pready=1.
- reg_out  out  NUM_REGS*32  flattened RW register contents; register i is at [32i+31:32i]. RO slots read 0.
- reg_in  in  NUM_REGS*32  flattened status inputs for RO registers; RW slots are ignored.
- reg_wr_stb  out  NUM_REGS  one-hot, one-cycle pulse after a successful write to register i.

Behaviour:
- Reset (preset_n=0, asynchronous):
  - state=IDLE, wait counter=0.
  - RW registers=RST_VAL.
  - pready=0, pslverr=0, prdata=0, reg_wr_stb=0.
- Decode, registered at the setup cycle:
  - off = paddr - BASE_ADDR; idx = off>>2.
  - hit = (off[1:0]==0) && (paddr>=BASE_ADDR) && (idx<NUM_REGS).
  - err = !hit || (pwrite && RO_MASK[idx]).
- FSM, states IDLE and ACCESS:
  - IDLE: psel=1 && penable=0 -> latch idx/err/pwrite, load cnt=WAIT_STATES, go to ACCESS. Anything else: stay.
  - ACCESS: if psel=0, abort -> IDLE with no side effects. Else if cnt!=0, cnt-1 and pready=0. Else pready=1.
  - Completion edge is psel && penable && pready -> IDLE. The next setup is accepted in the cycle immediately after (back-to-back transfers supported).
- Outputs:
  - pready = (state==ACCESS && cnt==0), decoded from registers with no combinational path from APB inputs.
  - With WAIT_STATES=0, pready is high in the first access cycle.
  - pslverr = pready && err_latched; 0 at all other times.
  - prdata = 0 unless pready && !pwrite_latched && !err_latched. Then it is the RW register value, or the reg_in slice for RO registers (combinational from reg_in in the completion cycle).
- Write commit, on the completion edge when there is no error: for each lane b with pstrb[b]=1, reg[idx][8b+7:8b] <= pwdata[8b+7:8b].
  - pstrb=0 is a legal write: no data change, strobe still pulses.
- Errored writes: no register change, no strobe. Errored reads: prdata=0.
- reg_wr_stb[idx] is high for exactly the cycle after the commit edge, coincident with the updated reg_out.
- Address and control are sampled at the setup cycle only. Changes to paddr/pwrite during ACCESS are ignored; pwdata/pstrb are sampled at the completion edge.
- Reset mid-transfer: immediate return to IDLE, pready=0, no partial write.
- Elaboration checks: DATA_W!=32, NUM_REGS out of range, WAIT_STATES>15, or BASE_ADDR unaligned -> $error.

Decomposition:
- Package apb_reg_pkg:
  - state_e {IDLE, ACCESS}.
  - APB_STRB_W=4, WORD_SHIFT=2, MAX_WAIT=15.
  - Function strb_merge(old, wdata, strb).
- Sub-module apb_addr_decode (combinational, parametrised by BASE_ADDR/NUM_REGS/RO_MASK): paddr, pwrite -> idx, hit, err.
- Top module holds the FSM, wait counter, register array and read mux.

Test Plan:
1. Write reg0 with pwdata=32'hDEAD_BEEF, pstrb=4'hF, WAIT_STATES=1 -> pready low for 1 access cycle then high, pslverr=0; next cycle reg_out[31:0]=DEAD_BEEF and reg_wr_stb=4'b0001. Readback of 0x0 gives prdata=DEAD_BEEF.
2. Partial strobe: reg1=32'h1122_3344, then write 32'hAABB_CCDD with pstrb=4'b0101 to 0x4 -> reg1=32'h11BB_33DD.
3. Write 32'h5 to RO reg3 (0xC) -> pslverr=1 at pready; reg_in slice unchanged in readback; no strobe. Read 0xC with reg_in[127:96]=32'hCAFE_0001 -> prdata=CAFE_0001, pslverr=0.
4. Error decode: read 0x10 (out of range) and read 0x2 (misaligned) -> pslverr=1, prdata=0.
5. Wait-state sweep WAIT_STATES=0 and WAIT_STATES=3 -> pready after exactly 0 and 3 stall cycles. Two back-to-back writes with no IDLE gap both complete correctly.
6. preset_n pulsed low during the ACCESS stall of a write of 32'h1234 to reg2 -> reg2=RST_VAL, pready=0, no strobe; the next transfer completes normally. Also: psel dropped mid-ACCESS -> no write.
